// File: rtl/credit_output_arbiter.sv
// Per-output-port scheduler: round-robin among head flits, wormhole lock until
// the tail flit, and credit-based flow control toward the downstream buffer.
module credit_output_arbiter #(
  parameter int NUM_IN    = 5,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req_i,
  input  logic [NUM_IN-1:0] head_i,
  input  logic [NUM_IN-1:0] tail_i,
  input  logic              credit_ret_i,
  output logic [NUM_IN-1:0] grant_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  credit_cnt_o,
  output logic              credit_en_o,
  output logic              locked_o,
  output logic [NUM_IN-1:0] owner_o,
  output logic              err_o
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUF_DEPTH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_IN-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               has_credit;
  logic [NUM_IN-1:0]  eligible;
  logic [NUM_IN-1:0]  win_oh;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic               win_tail;
  logic [PTR_W-1:0]   owner_idx;
  logic               owner_go;
  logic               owner_tail;
  logic [NUM_IN-1:0]  grant;
  logic               send;
  int                 scan_idx;

  assign has_credit = (cnt_q != '0);

  // Only head flits may open a new packet; body flits without an owner are ignored.
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_elig
    assign eligible[gi] = req_i[gi] & head_i[gi] & has_credit;
  end

  // Scan starts one past the last served port, so the last winner has lowest priority.
  always_comb begin
    win_oh    = '0;
    win_idx   = '0;
    win_found = 1'b0;
    scan_idx  = 0;
    for (int k = 1; k <= NUM_IN; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NUM_IN;
      if (!win_found && eligible[PTR_W'(scan_idx)]) begin
        win_found                = 1'b1;
        win_oh[PTR_W'(scan_idx)] = 1'b1;
        win_idx                  = PTR_W'(scan_idx);
      end
    end
  end

  assign win_tail = |(win_oh & tail_i);

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (owner_q[i]) owner_idx = PTR_W'(i);
    end
  end

  assign owner_go   = (|(owner_q & req_i)) & has_credit;
  assign owner_tail = |(owner_q & tail_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= PTR_W'(NUM_IN - 1);
      owner_q  <= '0;
      cnt_q    <= CNT_MAX;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          if (win_tail) begin
            rr_ptr_d = win_idx;
          end else begin
            state_d = LOCKED;
            owner_d = win_oh;
          end
        end
      end
      LOCKED: begin
        if (owner_go && owner_tail) begin
          state_d  = IDLE;
          rr_ptr_d = owner_idx;
          owner_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant = '0;
    case (state_q)
      IDLE:    grant = win_oh;
      LOCKED:  grant = owner_go ? owner_q : '0;
      default: grant = '0;
    endcase
  end

  assign send = |grant;

  // A return at full count saturates and flags the downstream protocol error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    case ({send, credit_ret_i})
      2'b10: cnt_d = cnt_q - 1'b1;
      2'b01: begin
        if (cnt_q == CNT_MAX) err_d = 1'b1;
        else                  cnt_d = cnt_q + 1'b1;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  assign grant_o      = grant;
  assign valid_o      = send;
  assign credit_cnt_o = cnt_q;
  assign credit_en_o  = has_credit;
  assign locked_o     = (state_q == LOCKED);
  assign owner_o      = owner_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_credit_output_arbiter.sv
// Directed bench for credit_output_arbiter: reset, round-robin, wormhole lock,
// credit exhaustion, credit overflow error and reset in mid-packet.
module tb_credit_output_arbiter;

  logic       clk;
  logic       rst;
  logic [4:0] req_i, head_i, tail_i;
  logic       credit_ret_i;
  logic [4:0] grant_o;
  logic       valid_o;
  logic [2:0] credit_cnt_o;
  logic       credit_en_o;
  logic       locked_o;
  logic [4:0] owner_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  credit_output_arbiter #(.NUM_IN(5), .BUF_DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .head_i(head_i), .tail_i(tail_i),
    .credit_ret_i(credit_ret_i),
    .grant_o(grant_o), .valid_o(valid_o),
    .credit_cnt_o(credit_cnt_o), .credit_en_o(credit_en_o),
    .locked_o(locked_o), .owner_o(owner_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; checks happen 2 units after that.
  task automatic drive(input logic [4:0] r, input logic [4:0] h,
                       input logic [4:0] t, input logic c);
    req_i = r; head_i = h; tail_i = t; credit_ret_i = c;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(5'b0, 5'b0, 5'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (credit_cnt_o !== 3'd4) begin errors++; $display("FAIL reset_cnt got %0d exp 4", credit_cnt_o); end
    checks++;
    if (locked_o !== 1'b0 || owner_o !== 5'b0) begin errors++; $display("FAIL reset_lock got locked=%b owner=%b exp 0/00000", locked_o, owner_o); end
    checks++;
    if (err_o !== 1'b0 || credit_en_o !== 1'b1) begin errors++; $display("FAIL reset_flags got err=%b en=%b exp 0/1", err_o, credit_en_o); end
    checks++;
    if (grant_o !== 5'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL reset_grant got %b valid=%b exp 00000/0", grant_o, valid_o); end
    $display("test_reset: cnt=%0d locked=%b err=%b", credit_cnt_o, locked_o, err_o);
  endtask

  task automatic test_single();
    do_reset();
    drive(5'b00001, 5'b00001, 5'b00001, 1'b0);
    checks++;
    if (grant_o !== 5'b00001 || valid_o !== 1'b1) begin errors++; $display("FAIL single_grant got %b valid=%b exp 00001/1", grant_o, valid_o); end
    tick();
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    checks++;
    if (credit_cnt_o !== 3'd3 || locked_o !== 1'b0) begin errors++; $display("FAIL single_after got cnt=%0d locked=%b exp 3/0", credit_cnt_o, locked_o); end
    // rr_ptr is now 0, so port 1 beats port 0
    drive(5'b00011, 5'b00011, 5'b00011, 1'b0);
    checks++;
    if (grant_o !== 5'b00010) begin errors++; $display("FAIL single_rrptr got %b exp 00010", grant_o); end
    tick();
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    checks++;
    if (credit_cnt_o !== 3'd2) begin errors++; $display("FAIL single_cnt2 got %0d exp 2", credit_cnt_o); end
    $display("test_single: cnt=%0d", credit_cnt_o);
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_g;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 5'b00001 : 5'b00100;
      drive(5'b00101, 5'b00101, 5'b00101, 1'b1);
      checks++;
      if (grant_o !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, grant_o, exp_g); end
      tick();
      checks++;
      if (credit_cnt_o !== 3'd4) begin errors++; $display("FAIL rr_cnt[%0d] got %0d exp 4", i, credit_cnt_o); end
      $display("test_round_robin: cycle %0d grant=%b cnt=%0d", i, exp_g, credit_cnt_o);
    end
    drive(5'b0, 5'b0, 5'b0, 1'b0);
  endtask

  task automatic test_wormhole();
    do_reset();
    // head of port 1 (no tail) vs single-flit at port 3
    drive(5'b01010, 5'b01010, 5'b01000, 1'b0);
    checks++;
    if (grant_o !== 5'b00010 || locked_o !== 1'b0) begin errors++; $display("FAIL wh_head got %b locked=%b exp 00010/0", grant_o, locked_o); end
    tick();
    drive(5'b01010, 5'b01000, 5'b01000, 1'b0);
    checks++;
    if (grant_o !== 5'b00010 || locked_o !== 1'b1 || owner_o !== 5'b00010) begin errors++; $display("FAIL wh_body got %b locked=%b owner=%b exp 00010/1/00010", grant_o, locked_o, owner_o); end
    tick();
    // owner stalls: nobody else may use the link
    drive(5'b01000, 5'b01000, 5'b01000, 1'b0);
    checks++;
    if (grant_o !== 5'b00000 || locked_o !== 1'b1) begin errors++; $display("FAIL wh_stall got %b locked=%b exp 00000/1", grant_o, locked_o); end
    tick();
    drive(5'b01010, 5'b01000, 5'b01010, 1'b0);
    checks++;
    if (grant_o !== 5'b00010 || locked_o !== 1'b1) begin errors++; $display("FAIL wh_tail got %b locked=%b exp 00010/1", grant_o, locked_o); end
    tick();
    drive(5'b01000, 5'b01000, 5'b01000, 1'b0);
    checks++;
    if (grant_o !== 5'b01000 || locked_o !== 1'b0 || credit_cnt_o !== 3'd1) begin errors++; $display("FAIL wh_next got %b locked=%b cnt=%0d exp 01000/0/1", grant_o, locked_o, credit_cnt_o); end
    tick();
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    checks++;
    if (credit_cnt_o !== 3'd0 || credit_en_o !== 1'b0) begin errors++; $display("FAIL wh_cnt0 got %0d en=%b exp 0/0", credit_cnt_o, credit_en_o); end
    $display("test_wormhole: cnt=%0d", credit_cnt_o);
  endtask

  task automatic test_credit_exhaust();
    logic [2:0] exp_c;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(5'b00001, 5'b00001, 5'b00001, 1'b0);
      checks++;
      if (grant_o !== 5'b00001) begin errors++; $display("FAIL ex_grant[%0d] got %b exp 00001", i, grant_o); end
      tick();
      exp_c = 3'(3 - i);
      checks++;
      if (credit_cnt_o !== exp_c) begin errors++; $display("FAIL ex_cnt[%0d] got %0d exp %0d", i, credit_cnt_o, exp_c); end
      $display("test_credit_exhaust: flit %0d cnt=%0d", i, credit_cnt_o);
    end
    drive(5'b00001, 5'b00001, 5'b00001, 1'b0);
    checks++;
    if (grant_o !== 5'b0 || valid_o !== 1'b0 || credit_en_o !== 1'b0) begin errors++; $display("FAIL ex_block got %b valid=%b en=%b exp 00000/0/0", grant_o, valid_o, credit_en_o); end
    tick();
    drive(5'b00001, 5'b00001, 5'b00001, 1'b1);
    checks++;
    if (grant_o !== 5'b0) begin errors++; $display("FAIL ex_retcycle got %b exp 00000", grant_o); end
    tick();
    drive(5'b00001, 5'b00001, 5'b00001, 1'b0);
    checks++;
    if (credit_cnt_o !== 3'd1 || grant_o !== 5'b00001) begin errors++; $display("FAIL ex_fifth got cnt=%0d grant=%b exp 1/00001", credit_cnt_o, grant_o); end
    tick();
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    checks++;
    if (credit_cnt_o !== 3'd0) begin errors++; $display("FAIL ex_final got %0d exp 0", credit_cnt_o); end
    $display("test_credit_exhaust: final cnt=%0d", credit_cnt_o);
  endtask

  task automatic test_err();
    do_reset();
    drive(5'b0, 5'b0, 5'b0, 1'b1);
    tick();
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    checks++;
    if (credit_cnt_o !== 3'd4 || err_o !== 1'b1) begin errors++; $display("FAIL err_set got cnt=%0d err=%b exp 4/1", credit_cnt_o, err_o); end
    drive(5'b00100, 5'b00100, 5'b00100, 1'b0);
    tick();
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    tick();
    checks++;
    if (credit_cnt_o !== 3'd3 || err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got cnt=%0d err=%b exp 3/1", credit_cnt_o, err_o); end
    $display("test_err: cnt=%0d err=%b", credit_cnt_o, err_o);
  endtask

  task automatic test_rst_locked();
    do_reset();
    drive(5'b0, 5'b0, 5'b0, 1'b1);
    tick();
    drive(5'b10000, 5'b10000, 5'b00000, 1'b0);
    tick();
    drive(5'b10000, 5'b00000, 5'b00000, 1'b0);
    tick();
    drive(5'b10000, 5'b00000, 5'b00000, 1'b0);
    checks++;
    if (locked_o !== 1'b1 || owner_o !== 5'b10000 || credit_cnt_o !== 3'd2 || err_o !== 1'b1) begin
      errors++; $display("FAIL rl_pre got locked=%b owner=%b cnt=%0d err=%b exp 1/10000/2/1", locked_o, owner_o, credit_cnt_o, err_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(5'b00001, 5'b00001, 5'b00001, 1'b0);
    checks++;
    if (locked_o !== 1'b0 || owner_o !== 5'b0 || credit_cnt_o !== 3'd4 || err_o !== 1'b0) begin
      errors++; $display("FAIL rl_post got locked=%b owner=%b cnt=%0d err=%b exp 0/00000/4/0", locked_o, owner_o, credit_cnt_o, err_o);
    end
    checks++;
    if (grant_o !== 5'b00001) begin errors++; $display("FAIL rl_newhead got %b exp 00001", grant_o); end
    tick();
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    $display("test_rst_locked: cnt=%0d locked=%b", credit_cnt_o, locked_o);
  endtask

  initial begin
    rst = 1'b1;
    req_i = '0; head_i = '0; tail_i = '0; credit_ret_i = 1'b0;
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_wormhole();
    test_credit_exhaust();
    test_err();
    test_rst_locked();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/credit_output_arbiter.md
Name: credit_output_arbiter

Overview:
- Per-output-port scheduler for the NoC router.
- Shares one downstream link between NUM_IN input ports using round-robin, with wormhole locking: a granted packet holds the link until its tail flit is sent.
- Tracks the credits available in the neighbouring router's input buffer and only sends a flit when at least one credit remains.
- Sits between the input-port buffers and the crossbar select for one output direction. One instance per output port.

Parameters:
- NUM_IN, 5, number of requesting input ports (N, S, E, W, local).
- BUF_DEPTH, 4, downstream buffer depth; this is the initial and maximum credit count.
- CNT_W, 3, credit counter width; must satisfy 2^CNT_W > BUF_DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous and active-high.
- req_i  in  NUM_IN  input port i has a flit waiting for this output.
- head_i  in  NUM_IN  the flit waiting at port i is a head flit.
- tail_i  in  NUM_IN  the flit waiting at port i is a tail flit. A single-flit packet has head and tail both set.
- credit_ret_i  in  1  downstream freed one buffer slot this cycle.
- grant_o  out  NUM_IN  one-hot; port i's flit is sent this cycle. Drives the crossbar select and the input-buffer pop.
- valid_o  out  1  a flit is on the link this cycle; equals OR of grant_o.
- credit_cnt_o  out  CNT_W  current credit count (registered).
- credit_en_o  out  1  credit_cnt_o != 0.
- locked_o  out  1  FSM is in the LOCKED state.
- owner_o  out  NUM_IN  one-hot owner while LOCKED; 0 otherwise.
- err_o  out  1  sticky flag: credit returned while the count was already at BUF_DEPTH.

Behaviour:
Reset (rst=1 at a clk edge):
- state=IDLE, credit_cnt_o=BUF_DEPTH, rr_ptr=NUM_IN-1, owner=0, err_o=0.
- Next-cycle combinational outputs: grant_o=0 unless requests are present; locked_o=0.

Timing:
- grant_o and valid_o are combinational from registered state plus req/head/tail (zero latency).
- State, pointer and counter update at the rising edge in the cycle of a grant.

Credit counter:
- send = valid_o.
- cnt_next = cnt - send + credit_ret_i.
- send and return in the same cycle: count unchanged.
- No send is possible at cnt=0. A return at cnt=0 gives cnt=1 next cycle; the flit waits one cycle.
- Return at cnt=BUF_DEPTH with no send: count saturates at BUF_DEPTH and err_o is set. err_o clears only on rst.

FSM state IDLE:
- Eligible port i: req_i & head_i & (cnt>0).
- Winner: first eligible port scanning from rr_ptr+1 upward, with wrap-around; assert grant_o for the winner.
- Winner with tail_i=0: go to LOCKED, owner=winner.
- Winner with tail_i=1: stay IDLE, rr_ptr=winner.
- Requests without head_i are ignored in IDLE (protocol violation; no grant is issued).

FSM state LOCKED:
- grant_o = owner when req_owner & (cnt>0); otherwise 0, and the state is held indefinitely.
- Other ports never receive a grant, even if the owner stalls.
- Owner flit sent with tail=1: go to IDLE, rr_ptr=owner, owner=0.
- A head_i seen at the owner while LOCKED is treated as a body flit (no error).

Other rules:
- Grants to non-owners: never, including in the cycle the owner's tail is sent. The next packet is granted no earlier than the following cycle.
- rst while LOCKED: packet state is abandoned and all reset values above apply. Upstream flushing is handled elsewhere.

Test Plan:
- Reset, then req_i=00001 with head=tail=1 for 1 cycle → grant_o=00001 same cycle; next cycle credit_cnt_o=3, locked_o=0, rr_ptr=0.
- Ports 0 and 2 both request single-flit packets continuously, with credit_ret_i=1 every cycle → grants alternate 00001, 00100, 00001, …; credit_cnt_o stays 4 after the first cycle.
- Port 1 sends a 3-flit packet (head, body, tail) while port 3 requests throughout → grant_o=00010 for 3 cycles, locked_o=1 for cycles 2–3; port 3 granted in cycle 4; counter drops 4→1.
- No credit returns, 5 single-flit requests from port 0 → 4 grants, then credit_en_o=0 and grant_o=0; a credit_ret_i pulse gives cnt=1, then the 5th flit is granted the following cycle and cnt returns to 0.
- At cnt=4, pulse credit_ret_i with no send → cnt stays 4, err_o=1 and remains set until rst.
- rst asserted mid-packet (LOCKED, owner=port 4, cnt=2) → next cycle locked_o=0, owner_o=0, credit_cnt_o=4, err_o=0; a new head at port 0 is granted immediately.
